// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: steps FETCH/DECODE/EXEC/MEM/WB with one-hot stage strobes.
// Define PERF_COUNTERS_EN to build the retired/cycle counters (width `WORD, default 32).
`ifndef WORD
`define WORD 32
`endif

module instr_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             halt_req_i,
  input  logic             reg_write_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic             branch_i,
  input  logic             uncondbranch_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             fetch_en_o,
  output logic             decode_en_o,
  output logic             read_en_o,
  output logic             exec_en_o,
  output logic             wb_en_o,
  output logic             mem_req_o,
  output logic             pc_src_o,
  output logic             busy_o,
  output logic             fault_o,
  output logic [2:0]       state_o,
  output logic [`WORD-1:0] retired_count_o,
  output logic [`WORD-1:0] cycle_count_o
);

  localparam int unsigned WaitW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_WAIT_MAX - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6,
    StFault  = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic             halt_q, halt_d;
  logic             reg_write_q, mem_read_q, mem_write_q, branch_q, uncond_q;
  logic [WaitW-1:0] wait_q;
  logic             pc_src_q, fetch_q, decode_q, exec_q, mem_q, wb_q, busy_q, fault_q;
  logic             retire;

  // A start in HALT clears the latch, but a concurrent halt_req re-arms it.
  assign halt_d = halt_req_i | (halt_q & ~((state_q == StHalt) & start_i));

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      StIdle:   if (start_i) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: state_d = StExec;
      StExec: begin
        if (mem_read_q | mem_write_q) state_d = StMem;
        else if (reg_write_q)         state_d = StWb;
        else                          retire  = 1'b1;
      end
      StMem: begin
        if (mem_ready_i) begin
          if (mem_read_q & reg_write_q) state_d = StWb;
          else                          retire  = 1'b1;
        end else if (wait_q == WaitLast) begin
          state_d = StFault;
        end
      end
      StWb:     retire = 1'b1;
      StHalt:   if (start_i) state_d = StFetch;
      StFault:  state_d = StFault;
    endcase
    if (retire) state_d = (halt_q | halt_req_i) ? StHalt : StFetch;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      halt_q      <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= 1'b0;
      uncond_q    <= 1'b0;
      wait_q      <= '0;
      pc_src_q    <= 1'b0;
      fetch_q     <= 1'b0;
      decode_q    <= 1'b0;
      exec_q      <= 1'b0;
      mem_q       <= 1'b0;
      wb_q        <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      halt_q   <= halt_d;
      fetch_q  <= (state_d == StFetch);
      decode_q <= (state_d == StDecode);
      exec_q   <= (state_d == StExec);
      mem_q    <= (state_d == StMem);
      wb_q     <= (state_d == StWb);
      busy_q   <= state_d inside {StFetch, StDecode, StExec, StMem, StWb};
      fault_q  <= (state_d == StFault);
      if (state_q == StDecode) begin
        reg_write_q <= reg_write_i;
        mem_read_q  <= mem_read_i;
        mem_write_q <= mem_write_i;
        branch_q    <= branch_i;
        uncond_q    <= uncondbranch_i;
      end
      if (state_q != StMem)  wait_q <= '0;
      else if (!mem_ready_i) wait_q <= wait_q + WaitW'(1);
      // Branch select lives until the redirected fetch has been issued.
      if (state_q == StExec)       pc_src_q <= uncond_q | (branch_q & zero_i);
      else if (state_q == StFetch) pc_src_q <= 1'b0;
    end
  end

  assign state_o     = state_q;
  assign fetch_en_o  = fetch_q;
  assign decode_en_o = decode_q;
  assign read_en_o   = decode_q;
  assign exec_en_o   = exec_q;
  assign mem_req_o   = mem_q;
  assign wb_en_o     = wb_q;
  assign pc_src_o    = pc_src_q;
  assign busy_o      = busy_q;
  assign fault_o     = fault_q;

`ifdef PERF_COUNTERS_EN
  logic [`WORD-1:0] retired_q, cycles_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retired_q <= '0;
      cycles_q  <= '0;
    end else begin
      if (retire) retired_q <= retired_q + `WORD'(1);
      if (busy_q) cycles_q  <= cycles_q + `WORD'(1);
    end
  end

  assign retired_count_o = retired_q;
  assign cycle_count_o   = cycles_q;
`else
  logic unused_retire;
  assign unused_retire   = retire;
  assign retired_count_o = '0;
  assign cycle_count_o   = '0;
`endif

endmodule
